// File: rtl/demux16_pkg.sv
// Shared constants and helpers for the buffered 1-to-16 demultiplexer.
package demux16_pkg;

  localparam int SLOTS = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 5;

  function automatic int slot_offset(input int idx, input int w);
    return idx * w;
  endfunction

  function automatic logic [CNT_W-1:0] popcount16(input logic [SLOTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < SLOTS; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/demux16_slot.sv
// Single-entry holding slot: one data register plus its occupied flag.
module demux16_slot #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             ack,
  output logic             valid,
  output logic [width-1:0] data
);

  logic             r_valid;
  logic [width-1:0] r_data;

  // A write takes priority over an ack so a same-cycle refill keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (wr_en) begin
      r_valid <= 1'b1;
      r_data  <= wr_data;
    end else if (ack) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/demux16x4_buf.sv
// Buffered 1-to-16 demux: steers each accepted word into one of 16 holding slots.
// Define DEMUX16_BYPASS_EN to let a slot being acked accept a new word in the same cycle.
module demux16x4_buf
  import demux16_pkg::*;
#(
  parameter int width = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width-1:0]       in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [SLOTS-1:0]       y_valid,
  output logic [SLOTS*width-1:0] y_data,
  input  logic [SLOTS-1:0]       y_ack,
  output logic [CNT_W-1:0]       count
);

  logic                 w_ready;
  logic                 w_accept;
  logic [SLOTS-1:0]     w_wr_en;
  logic [SLOTS-1:0]     w_ack_q;
  logic [CNT_W-1:0]     w_count_next;
  logic [CNT_W-1:0]     r_count;

  // Ready, select decode and next occupancy; acks to empty slots are masked out.
  always_comb begin
`ifdef DEMUX16_BYPASS_EN
    w_ready = ~y_valid[sel] | y_ack[sel];
`else
    w_ready = ~y_valid[sel];
`endif
    w_accept = in_valid & w_ready;
    w_ack_q  = y_ack & y_valid;
    if (w_accept) begin
      w_wr_en = {{(SLOTS-1){1'b0}}, 1'b1} << sel;
    end else begin
      w_wr_en = '0;
    end
    w_count_next = r_count + {{(CNT_W-1){1'b0}}, w_accept} - popcount16(w_ack_q);
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_slot
      demux16_slot #(.width(width)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en[g]),
        .wr_data (in_data),
        .ack     (w_ack_q[g]),
        .valid   (y_valid[g]),
        .data    (y_data[slot_offset(g, width) +: width])
      );
    end
  endgenerate

  assign in_ready = w_ready;
  assign count    = r_count;

endmodule

// File: tb/tb_demux16x4_buf.sv
// Directed and randomized bench for demux16x4_buf against an array-based slot model.
module tb_demux16x4_buf;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    sel;
  logic [15:0]   y_valid;
  logic [16*W-1:0] y_data;
  logic [15:0]   y_ack;
  logic [4:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  bit           mv[16];
  logic [W-1:0] md[16];

  demux16x4_buf #(.width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_ack    (y_ack),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0]     ev;
    logic [16*W-1:0] ed;
    int              c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      ev[i] = mv[i];
      ed[i*W +: W] = md[i];
      c += int'(mv[i]);
    end
    chk({tag, "_y_valid"}, y_valid, ev);
    chk({tag, "_y_data"}, y_data, ed);
    chk({tag, "_count"}, count, c);
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] s,
                      input logic [W-1:0] d, input logic [15:0] a);
    logic exp_rdy;
    logic acc;
    in_valid = v;
    sel      = s;
    in_data  = d;
    y_ack    = a;
    #1;
`ifdef DEMUX16_BYPASS_EN
    exp_rdy = !mv[s] || a[s];
`else
    exp_rdy = !mv[s];
`endif
    chk({tag, "_in_ready"}, in_ready, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      if (acc && i == int'(s)) begin
        mv[i] = 1'b1;
        md[i] = d;
      end else if (a[i] && mv[i]) begin
        mv[i] = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    sel      = '0;
    y_ack    = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Single write to the top slot.
    step("t1", 1'b1, 4'hF, 8'hA5, 16'h0000);
    chk("t1_valid_const", y_valid, 16'h8000);
    chk("t1_data15", y_data[15*W +: W], 8'hA5);
    chk("t1_count_const", count, 5'd1);
    step("t1_drain", 1'b0, 4'h0, 8'h00, 16'h8000);

    // Fill every slot with its own index, then confirm full backpressure.
    for (int i = 0; i < 16; i++) step("t2_fill", 1'b1, 4'(i), 8'(i), 16'h0000);
    chk("t2_count16", count, 5'd16);
    chk("t2_all_valid", y_valid, 16'hFFFF);
    chk("t2_slot9", y_data[9*W +: W], 8'h09);
    for (int i = 0; i < 16; i++) step("t2_full_rdy", 1'b1, 4'(i), 8'hEE, 16'h0000);

    // Ack and write the same full slot in one cycle.
    step("t3", 1'b1, 4'h3, 8'h33, 16'h0008);
`ifdef DEMUX16_BYPASS_EN
    chk("t3_v3", y_valid[3], 1'b1);
    chk("t3_d3", y_data[3*W +: W], 8'h33);
    chk("t3_cnt", count, 5'd16);
`else
    chk("t3_v3", y_valid[3], 1'b0);
    chk("t3_cnt", count, 5'd15);
`endif

    // Empty everything, then ack a full and an empty slot together.
    step("t4_clr", 1'b0, 4'h0, 8'h00, 16'hFFFF);
    step("t4_w1", 1'b1, 4'h1, 8'h11, 16'h0000);
    step("t4", 1'b0, 4'h0, 8'h00, 16'h0006);
    chk("t4_cnt", count, 5'd0);
    chk("t4_v2", y_valid[2], 1'b0);

    // Write one slot while draining a different one.
    step("t5_w7", 1'b1, 4'h7, 8'h77, 16'h0000);
    step("t5", 1'b1, 4'h4, 8'h44, 16'h0080);
    chk("t5_v4", y_valid[4], 1'b1);
    chk("t5_v7", y_valid[7], 1'b0);
    chk("t5_cnt", count, 5'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
           16'($urandom & $urandom & $urandom));
    end

    // Asynchronous reset in the middle of a cycle with five slots held.
    step("t6_clr", 1'b0, 4'h0, 8'h00, 16'hFFFF);
    for (int i = 0; i < 5; i++) step("t6_fill", 1'b1, 4'(i * 3), 8'(8'h50 + i), 16'h0000);
    chk("t6_cnt5", count, 5'd5);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("t6_async_valid", y_valid, 16'h0000);
    chk("t6_async_count", count, 5'd0);
    chk("t6_async_data", y_data, '0);
    #1;
    rst = 1'b0;
    step("t6_after", 1'b1, 4'hF, 8'hA5, 16'h0000);
    chk("t6_valid_const", y_valid, 16'h8000);
    chk("t6_count_const", count, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
